// File: rtl/vend_controller.sv
// Vending machine controller: a debounced keypad selects an item, coins are
// accumulated against its price, and the FSM either vends (with change) or
// refunds on cancel or inactivity.
module vend_controller #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int TIMEOUT_CYCLES  = 1000,
   parameter int PRICE0          = 15,
   parameter int PRICE1          = 20,
   parameter int PRICE2          = 25,
   parameter int PRICE3          = 40
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] row,
   input  logic [1:0] item_selected,
   input  logic [1:0] coin_in,
   input  logic       cancel,
   output logic       dispense,
   output logic [1:0] dispense_item,
   output logic       change_valid,
   output logic [7:0] change_amt,
   output logic [7:0] credit,
   output logic       busy
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PAY    = 2'd1,
      VEND   = 2'd2,
      REFUND = 2'd3
   } state_t;

   function automatic logic [7:0] price_of(input int idx);
      case (idx)
         0:       price_of = 8'(PRICE0);
         1:       price_of = 8'(PRICE1);
         2:       price_of = 8'(PRICE2);
         default: price_of = 8'(PRICE3);
      endcase
   endfunction

   // Price lookup indexed by item code
   logic [7:0] price_tbl [4];
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_price
         assign price_tbl[gi] = price_of(gi);
      end
   endgenerate

   state_t          state_reg, state_next;
   logic [7:0]      credit_reg, credit_next;
   logic [1:0]      item_reg, item_next;
   logic [7:0]      price_reg, price_next;
   logic [TW-1:0]   tmo_reg, tmo_next;
   logic            key_down_reg, key_down_next;
   logic [DW-1:0]   deb_cnt_reg, deb_cnt_next;
   logic            press_evt;
   logic            raw_pressed;
   logic [7:0]      coin_val;
   logic [8:0]      sum9;
   logic [7:0]      credit_sat;
   logic [7:0]      diff;

   assign raw_pressed = (row != 4'b1111);

   // Debounce: count consecutive cycles the raw level disagrees with the
   // debounced level; flip after DEBOUNCE_CYCLES and flag a press on 0->1.
   always_comb begin
      key_down_next = key_down_reg;
      deb_cnt_next  = '0;
      press_evt     = 1'b0;
      if (raw_pressed != key_down_reg) begin
         if (deb_cnt_reg == DW'(DEBOUNCE_CYCLES - 1)) begin
            key_down_next = raw_pressed;
            press_evt     = raw_pressed;
         end else begin
            deb_cnt_next = deb_cnt_reg + DW'(1);
         end
      end
   end

   // Coin decode and saturating credit accumulation
   always_comb begin
      case (coin_in)
         2'b01:   coin_val = 8'd5;
         2'b10:   coin_val = 8'd10;
         2'b11:   coin_val = 8'd20;
         default: coin_val = 8'd0;
      endcase
      sum9       = {1'b0, credit_reg} + {1'b0, coin_val};
      credit_sat = sum9[8] ? 8'hFF : sum9[7:0];
   end

   // FSM next-state and outputs; outputs decode from state so they are
   // single-cycle pulses in VEND/REFUND and forced low by reset.
   always_comb begin
      state_next    = state_reg;
      credit_next   = credit_reg;
      item_next     = item_reg;
      price_next    = price_reg;
      tmo_next      = tmo_reg;
      dispense      = 1'b0;
      dispense_item = 2'b00;
      change_valid  = 1'b0;
      change_amt    = 8'd0;
      diff          = 8'd0;
      case (state_reg)
         IDLE: begin
            if (press_evt) begin
               item_next  = item_selected;
               price_next = price_tbl[item_selected];
               tmo_next   = '0;
               state_next = PAY;
            end
         end
         PAY: begin
            credit_next = credit_sat;
            if (cancel) begin
               state_next = REFUND;
            end else if (credit_sat >= price_reg) begin
               state_next = VEND;
            end else if (coin_in != 2'b00) begin
               tmo_next = '0;
            end else if (tmo_reg == TW'(TIMEOUT_CYCLES - 1)) begin
               state_next = REFUND;
            end else begin
               tmo_next = tmo_reg + TW'(1);
            end
         end
         VEND: begin
            dispense      = 1'b1;
            dispense_item = item_reg;
            diff          = credit_reg - price_reg;
            if (diff != 8'd0) begin
               change_valid = 1'b1;
               change_amt   = diff;
            end
            credit_next = 8'd0;
            state_next  = IDLE;
         end
         default: begin
            if (credit_reg != 8'd0) begin
               change_valid = 1'b1;
               change_amt   = credit_reg;
            end
            credit_next = 8'd0;
            state_next  = IDLE;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         credit_reg   <= 8'd0;
         item_reg     <= 2'b00;
         price_reg    <= 8'd0;
         tmo_reg      <= '0;
         key_down_reg <= 1'b0;
         deb_cnt_reg  <= '0;
      end else begin
         state_reg    <= state_next;
         credit_reg   <= credit_next;
         item_reg     <= item_next;
         price_reg    <= price_next;
         tmo_reg      <= tmo_next;
         key_down_reg <= key_down_next;
         deb_cnt_reg  <= deb_cnt_next;
      end
   end

   assign credit = credit_reg;
   assign busy   = (state_reg != IDLE);

endmodule

// File: tb/tb_vend_controller.sv
// Directed testbench for vend_controller with default parameters.
module tb_vend_controller;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] row = 4'b1111;
   logic [1:0] item_selected = 2'b00;
   logic [1:0] coin_in = 2'b00;
   logic       cancel = 1'b0;
   logic       dispense;
   logic [1:0] dispense_item;
   logic       change_valid;
   logic [7:0] change_amt;
   logic [7:0] credit;
   logic       busy;

   int checks = 0;
   int errors = 0;

   vend_controller dut (
      .clk(clk), .rst_n(rst_n), .row(row), .item_selected(item_selected),
      .coin_in(coin_in), .cancel(cancel), .dispense(dispense),
      .dispense_item(dispense_item), .change_valid(change_valid),
      .change_amt(change_amt), .credit(credit), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Press a key for exactly the debounce time, then release long enough
   // for the release to be recognised.
   task automatic press(input logic [3:0] r, input logic [1:0] it);
      row = r; item_selected = it;
      repeat (16) step();
      row = 4'b1111;
      repeat (20) step();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) step();
      checks++;
      if ({dispense, dispense_item, change_valid, change_amt, credit, busy} !== 21'd0) begin
         errors++;
         $display("FAIL reset_outputs: got %h expected 0",
                  {dispense, dispense_item, change_valid, change_amt, credit, busy});
      end
      rst_n = 1'b1;
      step();
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle: busy %b expected 0", busy); end
      $display("test_reset done");
   endtask

   task automatic test_exact_pay();
      row = 4'b1101; item_selected = 2'b01;
      repeat (15) step();
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL press_15: busy %b expected 0", busy); end
      step();
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL press_16: busy %b expected 1", busy); end
      repeat (4) step();
      row = 4'b1111;
      repeat (20) step();
      coin_in = 2'b10; step();
      checks++;
      if (credit !== 8'd10 || dispense !== 1'b0) begin
         errors++; $display("FAIL exact_c1: credit %0d disp %b expected 10 0", credit, dispense);
      end
      step();
      coin_in = 2'b00;
      checks++;
      if (dispense !== 1'b1 || dispense_item !== 2'd1 || change_valid !== 1'b0 || change_amt !== 8'd0) begin
         errors++;
         $display("FAIL exact_vend: disp %b item %0d cv %b amt %0d expected 1 1 0 0",
                  dispense, dispense_item, change_valid, change_amt);
      end
      step();
      checks++;
      if (credit !== 8'd0 || busy !== 1'b0 || dispense !== 1'b0 || dispense_item !== 2'd0) begin
         errors++;
         $display("FAIL exact_after: credit %0d busy %b disp %b item %0d expected 0 0 0 0",
                  credit, busy, dispense, dispense_item);
      end
      $display("test_exact_pay done");
   endtask

   task automatic test_change();
      press(4'b1110, 2'b00);
      coin_in = 2'b11; step(); coin_in = 2'b00;
      checks++;
      if (dispense !== 1'b1 || dispense_item !== 2'd0 || change_valid !== 1'b1 || change_amt !== 8'd5) begin
         errors++;
         $display("FAIL change_vend: disp %b item %0d cv %b amt %0d expected 1 0 1 5",
                  dispense, dispense_item, change_valid, change_amt);
      end
      step();
      checks++;
      if (change_valid !== 1'b0 || change_amt !== 8'd0 || busy !== 1'b0) begin
         errors++; $display("FAIL change_after: cv %b amt %0d busy %b expected 0 0 0", change_valid, change_amt, busy);
      end
      $display("test_change done");
   endtask

   task automatic test_cancel();
      press(4'b0111, 2'b11);
      coin_in = 2'b10; step();
      coin_in = 2'b11; cancel = 1'b1; step();
      coin_in = 2'b00; cancel = 1'b0;
      checks++;
      if (change_valid !== 1'b1 || change_amt !== 8'd30 || dispense !== 1'b0) begin
         errors++;
         $display("FAIL cancel_refund: cv %b amt %0d disp %b expected 1 30 0", change_valid, change_amt, dispense);
      end
      coin_in = 2'b11; step(); coin_in = 2'b00;
      checks++;
      if (busy !== 1'b0 || credit !== 8'd0) begin
         errors++; $display("FAIL cancel_after: busy %b credit %0d expected 0 0", busy, credit);
      end
      // cancel wins over reaching the price (item 0, 10 + 10 >= 15)
      press(4'b1110, 2'b00);
      coin_in = 2'b10; step();
      cancel = 1'b1; step();
      coin_in = 2'b00; cancel = 1'b0;
      checks++;
      if (dispense !== 1'b0 || change_valid !== 1'b1 || change_amt !== 8'd20) begin
         errors++;
         $display("FAIL cancel_prio: disp %b cv %b amt %0d expected 0 1 20", dispense, change_valid, change_amt);
      end
      step();
      $display("test_cancel done");
   endtask

   task automatic test_timeout();
      press(4'b1011, 2'b10);
      coin_in = 2'b01; step(); coin_in = 2'b00;
      repeat (999) step();
      checks++;
      if (busy !== 1'b1 || change_valid !== 1'b0 || credit !== 8'd5) begin
         errors++;
         $display("FAIL tmo_999: busy %b cv %b credit %0d expected 1 0 5", busy, change_valid, credit);
      end
      step();
      checks++;
      if (change_valid !== 1'b1 || change_amt !== 8'd5 || dispense !== 1'b0) begin
         errors++;
         $display("FAIL tmo_refund: cv %b amt %0d disp %b expected 1 5 0", change_valid, change_amt, dispense);
      end
      step();
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL tmo_idle: busy %b expected 0", busy); end
      $display("test_timeout done");
   endtask

   task automatic test_glitch_hold();
      int busy_cnt;
      row = 4'b1110; item_selected = 2'b00; coin_in = 2'b11;
      repeat (10) step();
      row = 4'b1111;
      repeat (3) step();
      checks++;
      if (busy !== 1'b0 || credit !== 8'd0) begin
         errors++; $display("FAIL glitch: busy %b credit %0d expected 0 0", busy, credit);
      end
      row = 4'b1011; item_selected = 2'b10;
      repeat (15) step();
      checks++;
      if (busy !== 1'b0 || credit !== 8'd0) begin
         errors++; $display("FAIL hold_15: busy %b credit %0d expected 0 0", busy, credit);
      end
      coin_in = 2'b00;
      step();
      checks++;
      if (busy !== 1'b1 || credit !== 8'd0) begin
         errors++; $display("FAIL hold_16: busy %b credit %0d expected 1 0", busy, credit);
      end
      // Abort with zero credit: refund without a change pulse
      cancel = 1'b1; step(); cancel = 1'b0;
      checks++;
      if (change_valid !== 1'b0 || busy !== 1'b1) begin
         errors++; $display("FAIL zero_refund: cv %b busy %b expected 0 1", change_valid, busy);
      end
      busy_cnt = 0;
      repeat (83) begin
         step();
         if (busy) busy_cnt++;
      end
      checks++;
      if (busy_cnt !== 0) begin errors++; $display("FAIL held_key: busy cycles %0d expected 0", busy_cnt); end
      row = 4'b1111;
      repeat (20) step();
      $display("test_glitch_hold done");
   endtask

   task automatic test_reset_mid();
      press(4'b1011, 2'b10);
      coin_in = 2'b01; step();
      coin_in = 2'b10; step();
      coin_in = 2'b00;
      checks++;
      if (credit !== 8'd15 || busy !== 1'b1) begin
         errors++; $display("FAIL mid_credit: credit %0d busy %b expected 15 1", credit, busy);
      end
      row = 4'b1101; item_selected = 2'b01;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({dispense, dispense_item, change_valid, change_amt, credit, busy} !== 21'd0) begin
         errors++;
         $display("FAIL mid_reset: got %h expected 0",
                  {dispense, dispense_item, change_valid, change_amt, credit, busy});
      end
      repeat (3) begin
         step();
         checks++;
         if (change_valid !== 1'b0) begin errors++; $display("FAIL mid_nochange: cv %b expected 0", change_valid); end
      end
      rst_n = 1'b1;
      repeat (15) step();
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL post_rst_15: busy %b expected 0", busy); end
      step();
      checks++;
      if (busy !== 1'b1 || credit !== 8'd0) begin
         errors++; $display("FAIL post_rst_16: busy %b credit %0d expected 1 0", busy, credit);
      end
      cancel = 1'b1; step(); cancel = 1'b0;
      row = 4'b1111;
      repeat (20) step();
      $display("test_reset_mid done");
   endtask

   initial begin
      test_reset();
      test_exact_pay();
      test_change();
      test_cancel();
      test_timeout();
      test_glitch_hold();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
